inst_prefetch_queue: RTL and testbench
======================================

# inst_prefetch_queue

Instruction prefetch stage between `instruction_mem` and the `system` CPU core. It owns the fetch address, issues sequential word reads to the synchronous instruction memory, and buffers the returned instructions with their PCs in a small FIFO. It presents them to the core over a valid/ready handshake. A redirect from the core (branch/jump) flushes all buffered and in-flight fetches and restarts fetching at the new PC.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous reset, active-low (0 = reset).
- `imem_addr` out 32: byte address to `instruction_mem`; equals the internal fetch PC.
- `imem_req` out 1: a read of `imem_addr` is issued this cycle.
- `imem_data` in 32: instruction word, valid the cycle after `imem_req`.
- `redirect` in 1: flush and restart fetch, single-cycle pulse from the core.
- `redirect_pc` in 32: new fetch address; bits [1:0] are ignored and treated as 0.
- `inst_valid` out 1: FIFO head is valid.
- `inst_ready` in 1: the core accepts the head this cycle.
- `inst` out 32: head instruction.
- `inst_pc` out 32: address of the head instruction.

## Operation
- State:
  - fetch PC register.
  - FIFO of `DEPTH` entries of {pc, instr}, with read/write pointers and an occupancy count of width clog2(DEPTH+1).
  - 1-bit `inflight` flag, plus a latched pc for the in-flight read.
  - 1-bit `kill` flag.
- Pop: occurs when `inst_valid && inst_ready`.
- Issue rule: `imem_req = !redirect && (occupancy + inflight - pop) < DEPTH`.
  - A same-cycle pop frees a slot, so sustained throughput is 1 instruction per cycle.
- On issue:
  - Fetch PC advances by 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - `inflight` is set for the next cycle with the issued pc.
- Return: in the cycle after an issue, `{inflight_pc, imem_data}` is written into the FIFO, unless `kill` is set. A killed return is discarded.
- Redirect has priority over everything in the same cycle:
  - Fetch PC is loaded with `{redirect_pc[31:2],2'b00}`.
  - The FIFO is emptied (pointers and count go to 0).
  - Any pop that cycle is ignored.
  - Any return arriving that cycle is discarded.
  - `kill` is set if a request is in flight (`inflight` set this cycle).
  - No request is issued that cycle. Fetch resumes the next cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`.
- Full (count == `DEPTH`): no issue. Empty: `inst_valid` = 0, and `inst`/`inst_pc` hold their last values.

## Timing
- Reset values:
  - `imem_addr` = `RESET_PC`.
  - `imem_req` = 0 while reset is asserted.
  - `inst_valid` = 0, `inst` = 0, `inst_pc` = 0.
  - FIFO empty; `inflight` = 0; `kill` = 0; all statistics counters = 0.
- First request: `imem_req` = 1 in the first cycle after `rst` deasserts.
- Latency: `imem_req` in cycle n, `imem_data` sampled in cycle n+1, `inst_valid` earliest in cycle n+2.
- After a redirect in cycle r:
  - First request at `redirect_pc` in cycle r+1.
  - Its instruction is visible at the head in cycle r+3.
- `inst`, `inst_pc` and `inst_valid` are driven from registers/FIFO storage, with no combinational path from `inst_ready`.
- `imem_req` depends combinationally on `inst_ready` and `redirect`.
- Reset mid-operation: all state clears immediately (asynchronous). Any in-flight return is ignored.

## Configuration
- `PREFETCH_STATS_EN` defined:
  - Adds output ports `stat_fetches` (16-bit) and `stat_flushes` (16-bit).
  - `stat_fetches` increments on every issued request.
  - `stat_flushes` increments on every redirect.
  - Both saturate at 16'hFFFF and reset to 0.
- `PREFETCH_STATS_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, `inst_ready`=1, memory holds word k at address 4k: `imem_req` from the first cycle. First `inst_valid` two cycles later with `inst_pc`=0, then pcs 4, 8, 12… on consecutive cycles with no bubbles.
- `inst_ready`=0 from reset:
  - Exactly 4 requests are issued (addresses 0, 4, 8, 12), then `imem_req` stays 0.
  - `inst_valid` stays 1 with `inst_pc`=0.
  - Raising `inst_ready` drains pcs 0, 4, 8, 12 in order, and fetching resumes at 16.
- Redirect to 32'h0000_0103 while the FIFO holds 3 entries and one request is in flight:
  - `inst_valid` = 0 the next cycle and the stale return is dropped.
  - The next request is at 32'h0000_0100, and the first delivered `inst_pc` is 32'h0000_0100.
- Redirect and pop in the same cycle: the popped entry is not re-presented, and no entry older than the redirect appears afterwards.
- Redirect to 32'hFFFF_FFF8 with ready held high: delivered pcs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- `rst` asserted mid-stream with an in-flight request: outputs return to reset values immediately. After release, fetch restarts at `RESET_PC`, and no pre-reset instruction is delivered. With `PREFETCH_STATS_EN`, both counters read 0 after reset.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential reads to a synchronous instruction
// memory and buffers {pc, instr} pairs for the core. Optional macro: PREFETCH_STATS_EN.
module inst_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
`ifdef PREFETCH_STATS_EN
   ,
   output logic [15:0] stat_fetches,
   output logic [15:0] stat_flushes
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   fetch_pc, inflight_pc;
   logic          inflight, kill;

   logic          pop_raw, do_pop, push;
   logic [CW:0]   occ;
   logic [CW-1:0] remain;
   logic [PW-1:0] rd_next;
   logic          unused_bits;

   assign unused_bits = ^redirect_pc[1:0];

   assign imem_addr  = fetch_pc;
   assign inst_valid = (count != '0);
   assign inst       = head.instr;
   assign inst_pc    = head.pc;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      pop_raw  = 1'b0;
      do_pop   = 1'b0;
      push     = 1'b0;
      occ      = '0;
      remain   = '0;
      rd_next  = rd_ptr;
      imem_req = 1'b0;

      pop_raw  = inst_valid && inst_ready;
      do_pop   = pop_raw && !redirect;
      push     = inflight && !kill && !redirect;
      // A same-cycle pop frees a slot, so the issue check subtracts it.
      occ      = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop_raw);
      remain   = count - CW'(do_pop);
      rd_next  = rd_ptr + PW'(do_pop);
      imem_req = rst && !redirect && (occ < (CW+1)'(DEPTH));
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         kill        <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else if (redirect) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         kill     <= inflight;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         kill     <= 1'b0;
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
         end
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

   // NOTE: storage array is not reset; occupancy and the head register gate its visibility.
   always_ff @(posedge clk) begin
      if (push && rst) mem[wr_ptr] <= '{pc: inflight_pc, instr: imem_data};
   end

   // Head register preloads the next visible entry and holds its value when the queue empties.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
      end else if (!redirect) begin
         if (remain != '0)
            head <= mem[rd_next];
         else if (push)
            head <= '{pc: inflight_pc, instr: imem_data};
      end
   end

`ifdef PREFETCH_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_fetches <= '0;
         stat_flushes <= '0;
      end else begin
         if (imem_req && stat_fetches != 16'hFFFF) stat_fetches <= stat_fetches + 16'd1;
         if (redirect && stat_flushes != 16'hFFFF) stat_flushes <= stat_flushes + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: transaction-level reference model
// (arrival-time queue, expected fetch/delivery pcs) plus directed scenarios and random traffic.
module tb_inst_prefetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
`ifdef PREFETCH_STATS_EN
   logic [15:0] stat_fetches;
   logic [15:0] stat_flushes;
`endif

   inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_req    (imem_req),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc)
`ifdef PREFETCH_STATS_EN
      ,
      .stat_fetches(stat_fetches),
      .stat_flushes(stat_flushes)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a >> 2) ^ 32'h5A00_0000;
   endfunction

   // Synchronous instruction memory: data valid the cycle after the request.
   always @(posedge clk) begin
      if (imem_req) imem_data <= word_at(imem_addr);
   end

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          arrivals[$];
   logic [31:0] exp_addr, exp_pc;
   logic [31:0] delivered[$];
   int          dut_issues;
   int          model_issues, model_flushes;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      arrivals.delete();
      delivered.delete();
      exp_addr      = RESET_PC;
      exp_pc        = RESET_PC;
      dut_issues    = 0;
      model_issues  = 0;
      model_flushes = 0;
   endtask

   task automatic check_reset_outputs();
      check("rst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_inst",  inst,                32'd0);
      check("rst_pc",    inst_pc,             32'd0);
      check("rst_req",   {31'b0, imem_req},   32'd0);
      check("rst_addr",  imem_addr,           RESET_PC);
`ifdef PREFETCH_STATS_EN
      check("rst_stat_fetches", {16'b0, stat_fetches}, 32'd0);
      check("rst_stat_flushes", {16'b0, stat_flushes}, 32'd0);
`endif
   endtask

   // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
   task automatic tick();
      logic exp_valid, exp_req, pop;
      int   outstanding;
      @(negedge clk);
      exp_valid   = (arrivals.size() > 0) && (arrivals[0] <= cyc);
      outstanding = arrivals.size() - ((exp_valid && inst_ready) ? 1 : 0);
      exp_req     = !redirect && (outstanding < DEPTH);
      check("imem_req",   {31'b0, imem_req},   {31'b0, exp_req});
      check("imem_addr",  imem_addr,           exp_addr);
      check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
         check("inst_pc", inst_pc, exp_pc);
         check("inst",    inst,    word_at(exp_pc));
      end
      if (imem_req) dut_issues++;
      pop = exp_valid && inst_ready && !redirect;
      if (inst_valid && inst_ready && !redirect) delivered.push_back(inst_pc);
      if (redirect) begin
         arrivals.delete();
         exp_addr = {redirect_pc[31:2], 2'b00};
         exp_pc   = exp_addr;
         model_flushes++;
      end else begin
         if (pop) begin
            void'(arrivals.pop_front());
            exp_pc = exp_pc + 32'd4;
         end
         if (exp_req) begin
            arrivals.push_back(cyc + 2);
            exp_addr = exp_addr + 32'd4;
            model_issues++;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      redirect    = 1'b0;
      redirect_pc = '0;
      rst         = 1'b0;
      @(posedge clk);
      #2;
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic pulse_redirect(input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      tick();
      redirect    = 1'b0;
   endtask

   initial begin
      rst         = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b0;
      model_reset();

      // Streaming from reset with the core always ready.
      inst_ready = 1'b1;
      do_reset();
      repeat (12) tick();
      check("stream_pc0", delivered[0], 32'h0);
      check("stream_pc1", delivered[1], 32'h4);
      check("stream_pc3", delivered[3], 32'hC);

      // Core stalled from reset: exactly DEPTH requests, then drain and resume.
      inst_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      check("stall_issues", dut_issues, 32'd4);
      check("stall_head_pc", inst_pc, 32'h0);
      inst_ready = 1'b1;
      repeat (8) tick();
      check("drain_pc0", delivered[0], 32'h0);
      check("drain_pc3", delivered[3], 32'hC);
      check("drain_pc4", delivered[4], 32'h10);

      // Redirect with 3 buffered entries and one read in flight.
      inst_ready = 1'b0;
      do_reset();
      repeat (4) tick();
      pulse_redirect(32'h0000_0103);
      check("flush_valid", {31'b0, inst_valid}, 32'd0);
      check("flush_addr",  imem_addr,           32'h0000_0100);
      inst_ready = 1'b1;
      delivered.delete();
      repeat (6) tick();
      check("flush_first_pc", delivered[0], 32'h0000_0100);

      // Redirect in the same cycle as a pop.
      repeat (3) tick();
      pulse_redirect(32'h0000_0200);
      delivered.delete();
      repeat (6) tick();
      check("redir_pop_pc0", delivered[0], 32'h0000_0200);
      check("redir_pop_pc1", delivered[1], 32'h0000_0204);

      // Fetch address wrap at the top of the address space.
      pulse_redirect(32'hFFFF_FFF8);
      delivered.delete();
      repeat (7) tick();
      check("wrap_pc0", delivered[0], 32'hFFFF_FFF8);
      check("wrap_pc1", delivered[1], 32'hFFFF_FFFC);
      check("wrap_pc2", delivered[2], 32'h0000_0000);
      check("wrap_pc3", delivered[3], 32'h0000_0004);

      // Random backpressure and redirects.
      for (int i = 0; i < 400; i++) begin
         inst_ready  = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom();
         tick();
      end
      redirect   = 1'b0;
      inst_ready = 1'b1;
      repeat (6) tick();

      // Asynchronous reset mid-stream with a read in flight.
      do_reset();
      repeat (5) tick();
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      repeat (8) tick();
      check("post_rst_pc0", delivered[0], RESET_PC);
      check("post_rst_pc1", delivered[1], RESET_PC + 32'd4);

`ifdef PREFETCH_STATS_EN
      pulse_redirect(32'h0000_0040);
      repeat (3) tick();
      @(negedge clk);
      check("stat_fetches", {16'b0, stat_fetches}, model_issues);
      check("stat_flushes", {16'b0, stat_flushes}, model_flushes);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
